// File: rtl/dma_rd_path_tracker.sv
// dma_rd_path_tracker: binds DMA read requests to paths, counts completion beats per tag and emits AXI burst descriptors
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   req_valid/ready/tag/dev_addr/size   request issue (tag, AXI start address, byte count)
//   cpl_valid/ready/tag/dwen  completion beats matched by tag, dwen = contiguous dword enables
//   desc_valid/ready/path/addr/len/last burst descriptors {addr, awlen, last} with owning path
//   done_valid/tag            pulse once a request's last descriptor has been taken
//   err_valid/code/tag        1 unexpected tag, 2 overrun, 3 timeout
//   paths_busy                per-path non-FREE flags
module dma_rd_path_tracker #(
    parameter int P_PATHS      = 4,
    parameter int P_DATA_W     = 128,
    parameter int P_LEN_W      = 12,
    parameter int P_MAX_BURST  = 16,
    parameter int P_DESC_DEPTH = 4,
    parameter int P_TIMEOUT    = 4096
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [7:0]                 req_tag,
    input  logic [31:0]                req_dev_addr,
    input  logic [P_LEN_W-1:0]         req_size,
    input  logic                       cpl_valid,
    output logic                       cpl_ready,
    input  logic [7:0]                 cpl_tag,
    input  logic [P_DATA_W/32-1:0]     cpl_dwen,
    output logic                       desc_valid,
    input  logic                       desc_ready,
    output logic [$clog2(P_PATHS)-1:0] desc_path,
    output logic [31:0]                desc_addr,
    output logic [7:0]                 desc_len,
    output logic                       desc_last,
    output logic                       done_valid,
    output logic [7:0]                 done_tag,
    output logic                       err_valid,
    output logic [1:0]                 err_code,
    output logic [7:0]                 err_tag,
    output logic [P_PATHS-1:0]         paths_busy
);
    localparam int DW = P_DATA_W / 32;
    localparam int PW = $clog2(P_PATHS);
    localparam int QW = $clog2(P_DESC_DEPTH);
    localparam int TW = $clog2(P_TIMEOUT);
    localparam int CW = $clog2(P_MAX_BURST + 1);

    typedef enum logic [1:0] {FREE, ACTIVE, DRAIN} st_t;
    typedef struct packed {logic [31:0] addr; logic [7:0] len; logic last;} desc_t;

    st_t                st   [P_PATHS];
    logic [7:0]         tag  [P_PATHS];
    logic [P_LEN_W-1:0] size [P_PATHS];
    logic [31:0]        nxt  [P_PATHS];
    logic [31:0]        bst  [P_PATHS];
    logic [CW-1:0]      cnt  [P_PATHS];
    logic [TW-1:0]      tmo  [P_PATHS];
    desc_t              q    [P_PATHS][P_DESC_DEPTH];
    logic [QW-1:0]      wp   [P_PATHS];
    logic [QW-1:0]      rp   [P_PATHS];
    logic [QW:0]        qc   [P_PATHS];
    logic               live;
    logic [PW-1:0]      rr;

    logic [P_LEN_W-1:0] nb, sz_n [P_PATHS];
    logic [31:0]        nx_n [P_PATHS];
    logic [CW-1:0]      cnt_n [P_PATHS];
    desc_t              pd [P_PATHS];
    logic [P_PATHS-1:0] free_v, hold_req, hit, beat, acc, push, pop, ovr, tmo_hit, full_v, nonempty, in_out;
    logic [PW-1:0]      alloc, gnt, k;
    logic               any, load, part;
    logic [1:0]         e_code;
    logic [7:0]         e_tag;

    assign nb         = P_LEN_W'(4 * $countones(cpl_dwen));
    assign part       = $countones(cpl_dwen) < DW;
    assign req_ready  = live && |free_v && !(|hold_req);
    assign cpl_ready  = live && !(|full_v);
    assign paths_busy = ~free_v;
    // the output register takes a new descriptor only when empty or being consumed, so it holds while stalled
    assign load       = any && (!desc_valid || desc_ready);

    always_comb begin
        free_v = '0; hold_req = '0; hit = '0; beat = '0; acc = '0; push = '0; pop = '0;
        ovr = '0; tmo_hit = '0; full_v = '0; nonempty = '0; in_out = '0;
        alloc = '0; gnt = rr; k = '0; any = 1'b0; e_code = 2'd0; e_tag = 8'd0;
        for (int p = 0; p < P_PATHS; p++) begin
            free_v[p]   = st[p] == FREE;
            hold_req[p] = st[p] != FREE && tag[p] == req_tag;
            hit[p]      = st[p] == ACTIVE && tag[p] == cpl_tag;
            full_v[p]   = qc[p] == (QW+1)'(P_DESC_DEPTH);
            nonempty[p] = qc[p] != '0;
            in_out[p]   = desc_valid && desc_path == PW'(p);
        end
        for (int p = P_PATHS - 1; p >= 0; p--)
            alloc = free_v[p] ? PW'(p) : alloc;
        // scan downwards from rr+P_PATHS-1 so the first non-empty queue at or after rr wins
        for (int i = P_PATHS - 1; i >= 0; i--) begin
            k = PW'((int'(rr) + i) % P_PATHS);
            if (nonempty[k]) begin
                gnt = k;
                any = 1'b1;
            end
        end
        for (int p = 0; p < P_PATHS; p++) begin
            beat[p]    = cpl_valid && cpl_ready && hit[p];
            acc[p]     = req_valid && req_ready && alloc == PW'(p);
            sz_n[p]    = nb > size[p] ? '0 : size[p] - nb;
            nx_n[p]    = nxt[p] + 32'(nb);
            cnt_n[p]   = cnt[p] + 1'b1;
            push[p]    = beat[p] && (part || cnt_n[p] == CW'(P_MAX_BURST) || sz_n[p] == '0);
            pd[p]      = '{addr: bst[p], len: 8'(cnt[p]), last: sz_n[p] == '0};
            pop[p]     = load && gnt == PW'(p);
            ovr[p]     = beat[p] && nb > size[p];
            tmo_hit[p] = st[p] == ACTIVE && !beat[p] && tmo[p] == TW'(P_TIMEOUT - 1);
        end
        // later assignments override earlier ones: timeout (lowest path) > overrun > unexpected tag
        if (cpl_valid && cpl_ready && !(|hit)) begin
            e_code = 2'd1;
            e_tag  = cpl_tag;
        end
        if (|ovr) begin
            e_code = 2'd2;
            e_tag  = cpl_tag;
        end
        for (int p = P_PATHS - 1; p >= 0; p--)
            if (tmo_hit[p]) begin
                e_code = 2'd3;
                e_tag  = tag[p];
            end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            live <= 1'b0;
            rr <= '0;
            {desc_valid, desc_path, desc_addr, desc_len, desc_last} <= '0;
            {done_valid, done_tag, err_valid, err_code, err_tag} <= '0;
            for (int p = 0; p < P_PATHS; p++) begin
                st[p] <= FREE;
                tag[p] <= '0;
                size[p] <= '0;
                nxt[p] <= '0;
                bst[p] <= '0;
                cnt[p] <= '0;
                tmo[p] <= '0;
                wp[p] <= '0;
                rp[p] <= '0;
                qc[p] <= '0;
                for (int d = 0; d < P_DESC_DEPTH; d++)
                    q[p][d] <= '0;
            end
        end else begin
            live <= 1'b1;
            err_valid <= e_code != 2'd0;
            err_code <= e_code;
            err_tag <= e_tag;
            done_valid <= desc_valid && desc_ready && desc_last;
            done_tag <= tag[desc_path];
            if (desc_valid && desc_ready)
                desc_valid <= 1'b0;
            if (load) begin
                desc_valid <= 1'b1;
                desc_path <= gnt;
                {desc_addr, desc_len, desc_last} <= q[gnt][rp[gnt]];
                rr <= gnt == PW'(P_PATHS - 1) ? '0 : gnt + 1'b1;
            end
            for (int p = 0; p < P_PATHS; p++) begin
                if (acc[p]) begin
                    st[p] <= ACTIVE;
                    tag[p] <= req_tag;
                    size[p] <= req_size;
                    nxt[p] <= req_dev_addr;
                    bst[p] <= req_dev_addr;
                    cnt[p] <= '0;
                    tmo[p] <= '0;
                end else if (beat[p]) begin
                    size[p] <= sz_n[p];
                    nxt[p] <= nx_n[p];
                    tmo[p] <= '0;
                    cnt[p] <= push[p] ? '0 : cnt_n[p];
                    if (push[p])
                        bst[p] <= nx_n[p];
                    if (sz_n[p] == '0)
                        st[p] <= DRAIN;
                end else if (tmo_hit[p]) begin
                    // the open partial burst is dropped; already queued descriptors still drain
                    st[p] <= DRAIN;
                    cnt[p] <= '0;
                    bst[p] <= nxt[p];
                end else if (st[p] == ACTIVE) begin
                    tmo[p] <= tmo[p] + 1'b1;
                end else if (st[p] == DRAIN && !nonempty[p] && !in_out[p]) begin
                    st[p] <= FREE;
                end
                if (push[p]) begin
                    q[p][wp[p]] <= pd[p];
                    wp[p] <= wp[p] + 1'b1;
                end
                if (pop[p])
                    rp[p] <= rp[p] + 1'b1;
                qc[p] <= qc[p] + (QW+1)'(push[p]) - (QW+1)'(pop[p]);
            end
        end
    end
endmodule

// File: tb/tb_dma_rd_path_tracker.sv
// tb_dma_rd_path_tracker: randomized scoreboard bench for dma_rd_path_tracker against a request-level reference model
module tb_dma_rd_path_tracker;
    localparam int NP = 4;
    localparam int DW = 4;
    localparam int MB = 4;
    localparam int TO = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, cpl_valid, cpl_ready, desc_valid, desc_ready, desc_last;
    logic [7:0]  req_tag, cpl_tag, desc_len, done_tag, err_tag;
    logic [31:0] req_dev_addr, desc_addr;
    logic [11:0] req_size;
    logic [3:0]  cpl_dwen, paths_busy;
    logic [1:0]  desc_path, err_code;
    logic        done_valid, err_valid;

    always #5 clk = ~clk;

    dma_rd_path_tracker #(
        .P_PATHS(NP), .P_DATA_W(128), .P_LEN_W(12), .P_MAX_BURST(MB), .P_DESC_DEPTH(4), .P_TIMEOUT(TO)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag), .req_dev_addr(req_dev_addr), .req_size(req_size),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_tag(cpl_tag), .cpl_dwen(cpl_dwen),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_path(desc_path), .desc_addr(desc_addr),
        .desc_len(desc_len), .desc_last(desc_last),
        .done_valid(done_valid), .done_tag(done_tag),
        .err_valid(err_valid), .err_code(err_code), .err_tag(err_tag),
        .paths_busy(paths_busy)
    );

    typedef struct {int tag; logic [31:0] addr; int len; bit last;} dx_t;
    typedef struct {int code; int tag;} ex_t;

    dx_t         exp_d[$];
    ex_t         exp_e[$];
    int          checks = 0;
    int          fails = 0;
    bit          m_act [256];
    int          m_rem [256];
    int          m_cnt [256];
    logic [31:0] m_next [256];
    logic [31:0] m_bs [256];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push_err(input int code, input int t);
        ex_t e;
        e.code = code;
        e.tag = t;
        exp_e.push_back(e);
    endtask

    // request-level model: bytes consumed per beat, bursts close on partial beat, cap or exhaustion
    task automatic model_beat(input int t, input int n);
        int b;
        bit ov;
        dx_t d;
        b = 4 * n;
        if (!m_act[t]) begin
            push_err(1, t);
        end else begin
            ov = b > m_rem[t];
            m_rem[t] = ov ? 0 : m_rem[t] - b;
            m_cnt[t]++;
            if (n < DW || m_cnt[t] == MB || m_rem[t] == 0) begin
                d.tag = t;
                d.addr = m_bs[t];
                d.len = m_cnt[t] - 1;
                d.last = m_rem[t] == 0;
                exp_d.push_back(d);
                m_bs[t] = m_next[t] + b;
                m_cnt[t] = 0;
            end
            m_next[t] = m_next[t] + b;
            if (ov) push_err(2, t);
            if (m_rem[t] == 0) m_act[t] = 0;
        end
    endtask

    task automatic issue_req(input int t, input logic [31:0] a, input int sz);
        int w;
        w = 0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_tag = 8'(t);
        req_dev_addr = a;
        req_size = 12'(sz);
        @(negedge clk);
        while (!req_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("req_accept", req_ready, 1);
        if (req_ready) begin
            m_act[t] = 1;
            m_rem[t] = sz;
            m_next[t] = a;
            m_bs[t] = a;
            m_cnt[t] = 0;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic send_beat(input int t, input int n);
        int w;
        w = 0;
        @(posedge clk); #1;
        cpl_valid = 1'b1;
        cpl_tag = 8'(t);
        cpl_dwen = 4'((1 << n) - 1);
        @(negedge clk);
        while (!cpl_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("cpl_accept", cpl_ready, 1);
        if (cpl_ready) model_beat(t, n);
        @(posedge clk); #1;
        cpl_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int w;
        w = 0;
        while ((exp_d.size() != 0 || exp_e.size() != 0 || paths_busy != 0) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk(name, {exp_d.size() != 0, exp_e.size() != 0, paths_busy != 4'h0}, 0);
    endtask

    initial begin
        desc_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            desc_ready = $urandom_range(0, 3) != 0;
        end
    end

    // monitor: descriptors, done pulses and errors are popped from the scoreboard as the DUT presents them
    initial begin
        bit          hold, dpend, ok;
        logic [43:0] hv;
        int          dtag, idx;
        ex_t         e;
        hold = 0;
        dpend = 0;
        dtag = 0;
        hv = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 0;
                dpend = 0;
            end else begin
                if (dpend || done_valid) chk("done_valid", done_valid, dpend);
                if (dpend) chk("done_tag", done_tag, dtag);
                dpend = 0;
                if (hold) chk("desc_hold", {desc_valid, desc_path, desc_addr, desc_len, desc_last}, hv);
                hold = desc_valid && !desc_ready;
                hv = {desc_valid, desc_path, desc_addr, desc_len, desc_last};
                if (desc_valid && desc_ready) begin
                    idx = -1;
                    for (int i = 0; i < exp_d.size(); i++)
                        if (idx < 0 && exp_d[i].addr == desc_addr) idx = i;
                    if (idx < 0) begin
                        checks++;
                        fails++;
                        $display("FAIL desc_unexpected: got addr %h len %0d last %0d, none expected", desc_addr, desc_len, desc_last);
                    end else begin
                        ok = 1;
                        for (int j = 0; j < idx; j++)
                            if (exp_d[j].tag == exp_d[idx].tag) ok = 0;
                        chk("desc_order", ok, 1);
                        chk("desc_len", desc_len, exp_d[idx].len);
                        chk("desc_last", desc_last, exp_d[idx].last);
                        if (exp_d[idx].last) begin
                            dpend = 1;
                            dtag = exp_d[idx].tag;
                        end
                        exp_d.delete(idx);
                    end
                end
                if (err_valid) begin
                    if (exp_e.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL err_unexpected: got code %0d tag %0d, none expected", err_code, err_tag);
                    end else begin
                        e = exp_e.pop_front();
                        chk("err_code", err_code, e.code);
                        chk("err_tag", err_tag, e.tag);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog: run did not complete, expected completion before time limit");
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        int nreq, t, k, rd, n;
        int act_tags[$];
        req_valid = 0; req_tag = 0; req_dev_addr = 0; req_size = 0;
        cpl_valid = 0; cpl_tag = 0; cpl_dwen = 0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_cpl_ready", cpl_ready, 0);
        chk("rst_desc_valid", desc_valid, 0);
        chk("rst_flags", {done_valid, err_valid, paths_busy}, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("req_ready_after_reset", req_ready, 1);
        chk("cpl_ready_after_reset", cpl_ready, 1);

        issue_req(5, 32'h1000, 256);
        repeat (16) send_beat(5, 4);
        issue_req(6, 32'h2000, 80);
        repeat (5) send_beat(6, 4);
        issue_req(7, 32'h3000, 40);
        send_beat(7, 4);
        send_beat(7, 2);
        send_beat(7, 4);
        send_beat(9, 4);
        issue_req(8, 32'h4000, 8);
        send_beat(8, 4);
        wait_idle("directed_drain");

        nreq = 0;
        while (nreq < 40 || act_tags.size() > 0) begin
            if (nreq < 40 && act_tags.size() < 3 && $urandom_range(0, 2) == 0) begin
                t = 100 + nreq;
                issue_req(t, 32'h10000 * (nreq + 1) + 4 * $urandom_range(0, 255), 4 * $urandom_range(1, 48));
                act_tags.push_back(t);
                nreq++;
            end else if (act_tags.size() > 0) begin
                k = $urandom_range(0, act_tags.size() - 1);
                t = act_tags[k];
                rd = (m_rem[t] + 3) / 4;
                n = $urandom_range(1, rd < DW ? rd : DW);
                if (rd < DW && $urandom_range(0, 5) == 0) n = DW;
                if ($urandom_range(0, 15) == 0) send_beat(250, 4);
                send_beat(t, n);
                if (!m_act[t]) act_tags.delete(k);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        wait_idle("random_drain");

        issue_req(20, 32'h5000, 64);
        issue_req(21, 32'h6000, 64);
        issue_req(22, 32'h7000, 64);
        issue_req(23, 32'h8000, 64);
        req_tag = 8'd99;
        @(negedge clk);
        chk("req_ready_all_busy", req_ready, 0);
        chk("paths_busy_all", paths_busy, 4'hF);
        send_beat(20, 2);
        push_err(3, 21);
        push_err(3, 22);
        push_err(3, 23);
        push_err(3, 20);
        for (int i = 20; i < 24; i++) m_act[i] = 0;
        repeat (TO + 20) @(posedge clk);
        wait_idle("timeout_drain");

        issue_req(30, 32'h9000, 64);
        send_beat(30, 4);
        send_beat(30, 4);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", paths_busy, 0);
        chk("async_rst_ready", {req_ready, cpl_ready}, 0);
        chk("async_rst_outs", {desc_valid, done_valid, err_valid}, 0);
        m_act[30] = 0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        chk("end_desc_empty", exp_d.size(), 0);
        chk("end_err_empty", exp_e.size(), 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
